// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - live time in, edit status and load strobe out
interface time_set_ctrl_if;
  logic [7:0]  year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic        set_time;
  logic [47:0] bin_time;
  logic        editing;
  logic [2:0]  edit_field;
  logic        blink;

  modport master (
    output year, month, day, hour, minute, second,
    input  set_time, bin_time, editing, edit_field, blink
  );

  modport slave (
    input  year, month, day, hour, minute, second,
    output set_time, bin_time, editing, edit_field, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - four-button time/date editor with debounce, timeout and commit strobe
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_SEC     = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_1hz,
  input  logic [3:0]     sw_in,
  time_set_ctrl_if.slave tif
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int IW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_SEC - 1);

  typedef enum logic [2:0] {
    RUN, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT
  } state_t;

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
    logic [7:0] d;
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
      8'd2:                    d = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 d = 8'd31;
    endcase
    return d;
  endfunction

  // Out-of-range values snap to the opposite end, so a bad live load still recovers.
  function automatic logic [7:0] step_wrap(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi, input logic inc);
    logic [7:0] r;
    if (inc) r = (v >= hi || v < lo) ? lo : v + 8'd1;
    else     r = (v <= lo || v > hi) ? hi : v - 8'd1;
    return r;
  endfunction

  function automatic logic [7:0] clamp_day(input logic [7:0] d, input logic [7:0] dim);
    return (d > dim) ? dim : d;
  endfunction

  logic [3:0]     sync1, sync2, db_level, db_prev, armed;
  logic [1:0]     sync_fill;
  logic [DBW-1:0] db_cnt [4];
  logic [3:0]     press;

  // A button is armed only once seen released after reset, so a held key cannot fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_fill <= '0;
      armed     <= '0;
      db_level  <= '0;
      db_prev   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= sw_in;
      sync2   <= sync1;
      db_prev <= db_level;
      if (!sync_fill[1]) sync_fill <= sync_fill + 2'd1;
      else               armed     <= armed | ~sync2;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_level & ~db_prev & armed;

  logic p_mode, p_next, p_up, p_down, p_adj, any_press;
  assign p_mode    = press[3];
  assign p_next    = press[2];
  assign p_up      = press[1] & ~press[0];
  assign p_down    = press[0] & ~press[1];
  assign p_adj     = p_up | p_down;
  assign any_press = |press;

  state_t        state, state_n;
  logic [7:0]    sh_year, sh_month, sh_day, sh_hour, sh_min, sh_sec;
  logic [7:0]    yr_n, mo_n, dy_n, hr_n, mi_n, se_n;
  logic [IW-1:0] idle, idle_n;
  logic          blink, blink_n;
  logic          edit_n;
  logic [47:0]   bin_time;

  always_comb begin
    state_n = state;
    yr_n    = sh_year;
    mo_n    = sh_month;
    dy_n    = sh_day;
    hr_n    = sh_hour;
    mi_n    = sh_min;
    se_n    = sh_sec;
    case (state)
      RUN: begin
        if (p_mode) begin
          state_n = EDIT_YEAR;
          yr_n    = tif.year;
          mo_n    = tif.month;
          dy_n    = tif.day;
          hr_n    = tif.hour;
          mi_n    = tif.minute;
          se_n    = tif.second;
        end
      end
      COMMIT: state_n = RUN;
      default: begin
        if (p_mode) begin
          state_n = COMMIT;
        end else if (p_next) begin
          case (state)
            EDIT_YEAR:  state_n = EDIT_MONTH;
            EDIT_MONTH: state_n = EDIT_DAY;
            EDIT_DAY:   state_n = EDIT_HOUR;
            EDIT_HOUR:  state_n = EDIT_MIN;
            EDIT_MIN:   state_n = EDIT_SEC;
            default:    state_n = EDIT_YEAR;
          endcase
        end else if (p_adj) begin
          case (state)
            EDIT_YEAR: begin
              yr_n = step_wrap(sh_year, 8'd0, 8'd99, p_up);
              dy_n = clamp_day(sh_day, days_in_month(sh_month, yr_n));
            end
            EDIT_MONTH: begin
              mo_n = step_wrap(sh_month, 8'd1, 8'd12, p_up);
              dy_n = clamp_day(sh_day, days_in_month(mo_n, sh_year));
            end
            EDIT_DAY:  dy_n = step_wrap(sh_day, 8'd1, days_in_month(sh_month, sh_year), p_up);
            EDIT_HOUR: hr_n = step_wrap(sh_hour, 8'd0, 8'd23, p_up);
            EDIT_MIN:  mi_n = step_wrap(sh_min, 8'd0, 8'd59, p_up);
            default:   se_n = step_wrap(sh_sec, 8'd0, 8'd59, p_up);
          endcase
        end else if (en_1hz && idle == IDLE_LAST) begin
          state_n = RUN;
        end
      end
    endcase

    edit_n = (state_n != RUN) && (state_n != COMMIT);
    if (!edit_n || any_press) idle_n = '0;
    else if (en_1hz)          idle_n = idle + 1'b1;
    else                      idle_n = idle;
    if (!edit_n)        blink_n = 1'b0;
    else if (any_press) blink_n = 1'b1;
    else if (en_1hz)    blink_n = ~blink;
    else                blink_n = blink;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      sh_year  <= 8'd0;
      sh_month <= 8'd1;
      sh_day   <= 8'd1;
      sh_hour  <= 8'd0;
      sh_min   <= 8'd0;
      sh_sec   <= 8'd0;
      idle     <= '0;
      blink    <= 1'b0;
      bin_time <= '0;
    end else begin
      state    <= state_n;
      sh_year  <= yr_n;
      sh_month <= mo_n;
      sh_day   <= dy_n;
      sh_hour  <= hr_n;
      sh_min   <= mi_n;
      sh_sec   <= se_n;
      idle     <= idle_n;
      blink    <= blink_n;
      // Shadow is stable on the mode edge, so the load lines up with the COMMIT strobe.
      if (state_n == COMMIT)
        bin_time <= {sh_year, sh_month, sh_day, sh_hour, sh_min, sh_sec};
    end
  end

  logic [2:0] field;
  always_comb begin
    field = 3'd0;
    case (state)
      EDIT_MONTH: field = 3'd1;
      EDIT_DAY:   field = 3'd2;
      EDIT_HOUR:  field = 3'd3;
      EDIT_MIN:   field = 3'd4;
      EDIT_SEC:   field = 3'd5;
      default:    field = 3'd0;
    endcase
  end

  assign tif.set_time   = (state == COMMIT);
  assign tif.editing    = (state != RUN) && (state != COMMIT);
  assign tif.edit_field = field;
  assign tif.blink      = blink;
  assign tif.bin_time   = bin_time;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed vector bench for time_set_ctrl
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_1hz;
  logic [3:0] sw_in;

  time_set_ctrl_if tif();

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_SEC(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en_1hz (en_1hz),
    .sw_in  (sw_in),
    .tif    (tif)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] B_MODE = 4'h8, B_NEXT = 4'h4, B_UP = 4'h2, B_DOWN = 4'h1;
  localparam logic [47:0] LIVE_A = {8'd24, 8'd2, 8'd28, 8'd13, 8'd45, 8'd10};
  localparam logic [47:0] LIVE_B = {8'd23, 8'd1, 8'd31, 8'd12, 8'd0, 8'd0};
  localparam logic [47:0] LIVE_C = {8'd0, 8'd5, 8'd15, 8'd0, 8'd59, 8'd0};
  localparam logic [47:0] BIN_A  = {8'd24, 8'd2, 8'd1, 8'd13, 8'd45, 8'd10};
  localparam logic [47:0] BIN_B  = {8'd23, 8'd2, 8'd28, 8'd12, 8'd0, 8'd0};
  localparam logic [47:0] BIN_C  = {8'd99, 8'd5, 8'd15, 8'd1, 8'd0, 8'd0};

  typedef struct {
    logic [3:0]  btns;
    logic [47:0] live;
    logic        exp_edit;
    logic [2:0]  exp_field;
    int          exp_strobes;
    logic [47:0] exp_bin;
  } vec_t;

  vec_t vecs[24];
  int total = 0;
  int bad = 0;
  int strobes = 0;

  always @(negedge clk) if (tif.set_time) strobes++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_live(input logic [47:0] t);
    {tif.year, tif.month, tif.day, tif.hour, tif.minute, tif.second} = t;
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    @(posedge clk); #1 sw_in = b;
    repeat (hold) @(posedge clk);
    #1 sw_in = 4'h0;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic pulse_1hz();
    @(posedge clk); #1 en_1hz = 1'b1;
    @(posedge clk); #1 en_1hz = 1'b0;
    repeat (2) @(negedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{B_MODE,        LIVE_A, 1'b1, 3'd0, 0, 48'h0};
    vecs[1]  = '{B_NEXT,        LIVE_A, 1'b1, 3'd1, 0, 48'h0};
    vecs[2]  = '{B_NEXT,        LIVE_A, 1'b1, 3'd2, 0, 48'h0};
    vecs[3]  = '{B_UP,          LIVE_A, 1'b1, 3'd2, 0, 48'h0};
    vecs[4]  = '{B_UP,          LIVE_A, 1'b1, 3'd2, 0, 48'h0};
    vecs[5]  = '{B_MODE,        LIVE_A, 1'b0, 3'd0, 1, BIN_A};
    vecs[6]  = '{B_MODE,        LIVE_B, 1'b1, 3'd0, 1, BIN_A};
    vecs[7]  = '{B_NEXT,        LIVE_B, 1'b1, 3'd1, 1, BIN_A};
    vecs[8]  = '{B_UP,          LIVE_B, 1'b1, 3'd1, 1, BIN_A};
    vecs[9]  = '{B_MODE,        LIVE_B, 1'b0, 3'd0, 2, BIN_B};
    vecs[10] = '{B_MODE | B_UP, LIVE_C, 1'b1, 3'd0, 2, BIN_B};
    vecs[11] = '{B_DOWN,        LIVE_A, 1'b1, 3'd0, 2, BIN_B};
    vecs[12] = '{B_NEXT,        LIVE_A, 1'b1, 3'd1, 2, BIN_B};
    vecs[13] = '{B_NEXT,        LIVE_A, 1'b1, 3'd2, 2, BIN_B};
    vecs[14] = '{B_NEXT,        LIVE_A, 1'b1, 3'd3, 2, BIN_B};
    vecs[15] = '{B_UP | B_DOWN, LIVE_A, 1'b1, 3'd3, 2, BIN_B};
    vecs[16] = '{B_UP,          LIVE_A, 1'b1, 3'd3, 2, BIN_B};
    vecs[17] = '{B_NEXT,        LIVE_A, 1'b1, 3'd4, 2, BIN_B};
    vecs[18] = '{B_UP,          LIVE_A, 1'b1, 3'd4, 2, BIN_B};
    vecs[19] = '{B_NEXT,        LIVE_A, 1'b1, 3'd5, 2, BIN_B};
    vecs[20] = '{B_NEXT,        LIVE_A, 1'b1, 3'd0, 2, BIN_B};
    vecs[21] = '{B_MODE,        LIVE_A, 1'b0, 3'd0, 3, BIN_C};
    vecs[22] = '{B_NEXT,        LIVE_A, 1'b0, 3'd0, 3, BIN_C};
    vecs[23] = '{B_UP,          LIVE_A, 1'b0, 3'd0, 3, BIN_C};

    rst = 1'b1; en_1hz = 1'b0; sw_in = 4'h0; set_live(48'h0);
    repeat (3) @(negedge clk); #1;
    check("reset editing", 64'(tif.editing), 64'd0);
    check("reset field", 64'(tif.edit_field), 64'd0);
    check("reset blink", 64'(tif.blink), 64'd0);
    check("reset set_time", 64'(tif.set_time), 64'd0);
    check("reset bin_time", 64'(tif.bin_time), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      set_live(vecs[i].live);
      press(vecs[i].btns, 8);
      check($sformatf("vec%0d editing", i), 64'(tif.editing), 64'(vecs[i].exp_edit));
      check($sformatf("vec%0d field", i), 64'(tif.edit_field), 64'(vecs[i].exp_field));
      check($sformatf("vec%0d blink", i), 64'(tif.blink), 64'(vecs[i].exp_edit));
      check($sformatf("vec%0d strobes", i), 64'(strobes), 64'(vecs[i].exp_strobes));
      check($sformatf("vec%0d bin_time", i), 64'(tif.bin_time), 64'(vecs[i].exp_bin));
    end

    @(posedge clk); #1 sw_in = B_MODE;
    repeat (3) @(posedge clk);
    #1 sw_in = 4'h0;
    repeat (14) @(negedge clk); #1;
    check("glitch ignored", 64'(tif.editing), 64'd0);

    press(B_MODE, 20);
    check("long hold enters edit", 64'(tif.editing), 64'd1);
    check("long hold single press", 64'(strobes), 64'd3);

    pulse_1hz();
    check("tick1 blink", 64'(tif.blink), 64'd0);
    check("tick1 editing", 64'(tif.editing), 64'd1);
    pulse_1hz();
    check("tick2 blink", 64'(tif.blink), 64'd1);
    check("tick2 editing", 64'(tif.editing), 64'd1);
    pulse_1hz();
    check("timeout editing", 64'(tif.editing), 64'd0);
    check("timeout blink", 64'(tif.blink), 64'd0);
    check("timeout no strobe", 64'(strobes), 64'd3);

    press(B_MODE, 8);
    for (int i = 0; i < 4; i++) press(B_NEXT, 8);
    check("reach edit_min", 64'(tif.edit_field), 64'd4);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async rst editing", 64'(tif.editing), 64'd0);
    check("async rst field", 64'(tif.edit_field), 64'd0);
    check("async rst blink", 64'(tif.blink), 64'd0);
    check("async rst set_time", 64'(tif.set_time), 64'd0);
    check("async rst bin_time", 64'(tif.bin_time), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk); #1;
    check("post rst editing", 64'(tif.editing), 64'd0);
    check("post rst no strobe", 64'(strobes), 64'd3);

    @(posedge clk); #1 sw_in = B_MODE; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk); #1;
    check("held through reset", 64'(tif.editing), 64'd0);
    @(posedge clk); #1 sw_in = 4'h0;
    repeat (12) @(negedge clk);
    set_live(LIVE_A);
    press(B_MODE, 8);
    check("repress after reset", 64'(tif.editing), 64'd1);
    press(B_MODE, 8);
    check("final strobes", 64'(strobes), 64'd4);
    check("final bin_time", 64'(tif.bin_time), 64'(LIVE_A));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, clk cycles a button must be stable before it is accepted.
REQ-002 Parameter TIMEOUT_SEC, default 30, en_1hz ticks without a press before edit mode is abandoned.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en_1hz  input  1  one-clk-wide 1 Hz enable.
REQ-006 sw_in  input  4  raw buttons, active-high: [3]=mode, [2]=next, [1]=up, [0]=down.
REQ-007 year, month, day, hour, minute, second  input  8 each  live binary time (year 0-99).
REQ-008 set_time  output  1  one-clk load strobe to the timekeeper.
REQ-009 bin_time  output  48  {year,month,day,hour,minute,second}, 8 bits each, binary.
REQ-010 editing  output  1  high in any EDIT_* state.
REQ-011 edit_field  output  3  0=year,1=month,2=day,3=hour,4=minute,5=second; 0 outside edit.
REQ-012 blink  output  1  display blink phase for the selected field.

Function
REQ-013 Each sw_in bit SHALL pass a 2-flop synchronizer, then a debounce counter; level accepted after DEBOUNCE_CYCLES consecutive equal samples.
REQ-014 Each accepted 0->1 transition SHALL produce exactly one 1-clk press pulse; holding produces no repeat.
REQ-015 Same-cycle press priority: mode > next > up/down; up and down together SHALL be ignored.
REQ-016 States: RUN, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
REQ-017 RUN + mode press: shadow regs load live inputs same edge; next state EDIT_YEAR.
REQ-018 RUN: next/up/down presses ignored.
REQ-019 EDIT_* + next: advance year->month->day->hour->min->sec->year (wrap).
REQ-020 EDIT_* + mode: go to COMMIT; COMMIT lasts exactly 1 clk, asserts set_time, then RUN.
REQ-021 bin_time SHALL equal shadow regs whenever set_time=1; it holds last value otherwise.
REQ-022 up/down modify selected shadow field by +/-1 with wrap: year 0-99, month 1-12, hour 0-23, minute 0-59, second 0-59, day 1..dim.
REQ-023 dim = 31 (months 1,3,5,7,8,10,12), 30 (4,6,9,11), February 29 if year%4==0 else 28.
REQ-024 After any month or year change, day SHALL be clamped to new dim on the same edge.
REQ-025 Live inputs are not re-sampled during edit; timekeeper runs unaffected until set_time.
REQ-026 Idle counter: cleared by any press, incremented on en_1hz in EDIT_*; reaching TIMEOUT_SEC SHALL return to RUN without set_time.
REQ-027 blink toggles on en_1hz in EDIT_*; forced to 1 on any accepted press; 0 in RUN/COMMIT.
REQ-028 set_time never asserts outside COMMIT; max one strobe per edit session.

Reset
REQ-029 rst=1 SHALL asynchronously force: state RUN, set_time 0, bin_time 0, editing 0, edit_field 0, blink 0, idle counter 0, debounce/sync regs 0, shadow regs {0,1,1,0,0,0}.
REQ-030 Reset mid-edit SHALL discard shadow values; no set_time on release.
REQ-031 Buttons held through reset release SHALL not generate a press until released and re-pressed.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_SEC=3 in bench)
REQ-032 Live 24-02-28 13:45:10, mode, next x2, up x2, mode -> one set_time with bin_time {24,2,1,13,45,10} (day 28->29->1 wrap, leap).
REQ-033 Shadow 23-01-31, next to month, up -> month 2, day clamped to 28; down on year 0 -> 99.
REQ-034 Sw glitch shorter than 4 clk -> no press; 20-clk hold -> single press only.
REQ-035 In edit, no press for 3 en_1hz -> RUN, editing 0, set_time never asserted.
REQ-036 mode+up same cycle in RUN -> EDIT_YEAR, shadow year unchanged; up+down in EDIT_HOUR -> no change.
REQ-037 rst asserted in EDIT_MIN -> all outputs reset values immediately, no set_time after release.
